// File: rtl/rr_mux_reg_pkg.sv
// rr_mux_reg_pkg: shared arbitration mode encodings and index helper for rr_mux_reg
package rr_mux_reg_pkg;
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR = 1'b1;
  function automatic int wrap_idx(int i, int n);
    return i % n;
  endfunction
endpackage

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: producer/consumer bus of rr_mux_reg
//   master (environment): drives mode, in_data, in_valid, out_ready
//   slave  (rr_mux_reg):  drives in_ready, out_data, out_sel, out_valid
//   out_parity is present only when RR_MUX_PARITY_EN is defined
interface rr_mux_reg_if #(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);
  logic mode;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_sel;
  logic out_valid;
  logic out_ready;
`ifdef RR_MUX_PARITY_EN
  logic out_parity;
`endif
  modport master (
    output mode, in_data, in_valid, out_ready,
`ifdef RR_MUX_PARITY_EN
    input out_parity,
`endif
    input in_ready, out_data, out_sel, out_valid
  );
  modport slave (
    input mode, in_data, in_valid, out_ready,
`ifdef RR_MUX_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// rr_arbiter: combinational fixed-priority / round-robin grant selection
//   req       requesting channels
//   last      most recent grant (round-robin search starts just after it)
//   mode      MUX_MODE_FIXED (lowest index wins) or MUX_MODE_RR
//   grant_oh  one-hot grant, grant_idx its index, any = some request present
module rr_arbiter
  import rr_mux_reg_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last,
  input  logic              mode,
  output logic [NUM_IN-1:0] grant_oh,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);
  logic found;
  assign any = |req;
  always_comb begin
    grant_oh = '0;
    grant_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      automatic int idx = (mode == MUX_MODE_RR) ? wrap_idx(int'(last) + 1 + k, NUM_IN) : k;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
    grant_oh[grant_idx] = found;
  end
endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NUM_IN-way WIDTH-bit arbitrated mux with a 1-entry registered output
//   clk, rst  clock and asynchronous active-high reset
//   bus       rr_mux_reg_if slave: per-channel valid/ready inputs, registered output
//   RR_MUX_PARITY_EN adds out_parity = ^out_data, registered with out_data
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 4
) (
  input logic clk,
  input logic rst,
  rr_mux_reg_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  logic [NUM_IN-1:0] grant_oh;
  logic [SEL_W-1:0] grant_idx;
  logic any, load;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d, last_q, last_d;
  logic out_valid_q, out_valid_d;
  rr_arbiter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_arb (
    .req(bus.in_valid),
    .last(last_q),
    .mode(bus.mode),
    .grant_oh(grant_oh),
    .grant_idx(grant_idx),
    .any(any)
  );
  // The register may refill whenever it is empty or being drained this cycle.
  assign load = any & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = load ? grant_oh : '0;
  // AND-OR select keyed by the one-hot grant, so no priority chain on data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_oh[i]}});
  end
  always_comb begin
    out_data_d = load ? sel_data : out_data_q;
    out_sel_d = load ? grant_idx : out_sel_q;
    out_valid_d = load | (out_valid_q & ~bus.out_ready);
    last_d = load ? grant_idx : last_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_sel_q <= '0;
      out_valid_q <= 1'b0;
      last_q <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q <= last_d;
    end
  end
  assign bus.out_data = out_data_q;
  assign bus.out_sel = out_sel_q;
  assign bus.out_valid = out_valid_q;
`ifdef RR_MUX_PARITY_EN
  logic out_parity_q, out_parity_d;
  always_comb out_parity_d = load ? ^sel_data : out_parity_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_parity_q <= 1'b0;
    else out_parity_q <= out_parity_d;
  end
  assign bus.out_parity = out_parity_q;
`endif
endmodule
